// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor: alignment check, strobe/lane build, SRAM-like
// req/addr_ok/data_ok handshake with timeout and flush, load extraction.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        ex_ready,
  input  logic        flush,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_adel,
  output logic        resp_ades,
  output logic        resp_buserr
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYC);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      op_reg;
  logic            ex_ready_reg, busy_reg, bus_req_reg, bus_wr_reg;
  logic [3:0]      wstrb_reg;
  logic [31:0]     addr_reg, wdata_reg;
  logic            resp_valid_reg, adel_reg, ades_reg, buserr_reg;
  logic [31:0]     rdata_reg;
  logic            adel_next, ades_next, buserr_next;
  logic [31:0]     rdata_next;

  logic            accept, in_load, in_mis;
  logic [3:0]      strb_in;
  logic [31:0]     wdata_in;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     load_val;

  assign accept  = ex_ready_reg & ex_valid & ~flush;
  assign in_load = (ex_memop <= 3'd4);

  always_comb begin
    in_mis  = 1'b0;
    strb_in = 4'b0000;
    case (ex_memop)
      3'b000, 3'b111:         in_mis = (ex_addr[1:0] != 2'b00);
      3'b001, 3'b010, 3'b110: in_mis = ex_addr[0];
      default:                in_mis = 1'b0;
    endcase
    case (ex_memop)
      3'b101:  strb_in = 4'b0001 << ex_addr[1:0];
      3'b110:  strb_in = 4'b0011 << {ex_addr[1], 1'b0};
      3'b111:  strb_in = 4'b1111;
      default: strb_in = 4'b0000;
    endcase
  end

  // Store data replicated so every byte lane carries the right slice
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wdata_in[8*gi +: 8] =
        (ex_memop == 3'b101) ? ex_wdata[7:0] :
        (ex_memop == 3'b110) ? ex_wdata[8*(gi%2) +: 8] :
        (ex_memop == 3'b111) ? ex_wdata[8*gi +: 8] : 8'h00;
  end

  assign rbyte = bus_rdata[{addr_reg[1:0], 3'b000} +: 8];
  assign rhalf = addr_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (op_reg)
      3'b000:  load_val = bus_rdata;
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b010:  load_val = {16'h0000, rhalf};
      3'b011:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'h000000, rbyte};
      default: load_val = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    adel_next   = 1'b0;
    ades_next   = 1'b0;
    buserr_next = 1'b0;
    rdata_next  = 32'h0000_0000;
    case (state_reg)
      IDLE: if (accept) begin
        cnt_next = '0;
        if (in_mis) begin
          state_next = RESP;
          adel_next  = in_load;
          ades_next  = ~in_load;
        end else begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        cnt_next = cnt_reg + CW'(1);
        if (flush) begin
          // A flush racing addr_ok still owes the bus its data phase
          if (!bus_addr_ok || bus_data_ok) state_next = IDLE;
          else                             state_next = DRAIN;
        end else if (bus_addr_ok && bus_data_ok) begin
          state_next = RESP;
          rdata_next = load_val;
        end else if (bus_addr_ok) begin
          state_next = DATA;
        end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          state_next  = RESP;
          buserr_next = 1'b1;
        end
      end
      DATA: begin
        cnt_next = cnt_reg + CW'(1);
        if (flush) begin
          state_next = bus_data_ok ? IDLE : DRAIN;
        end else if (bus_data_ok) begin
          state_next = RESP;
          rdata_next = load_val;
        end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          state_next  = RESP;
          buserr_next = 1'b1;
        end
      end
      DRAIN:   if (bus_data_ok) state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      op_reg         <= 3'b000;
      ex_ready_reg   <= 1'b1;
      busy_reg       <= 1'b0;
      bus_req_reg    <= 1'b0;
      bus_wr_reg     <= 1'b0;
      wstrb_reg      <= 4'b0000;
      addr_reg       <= 32'h0000_0000;
      wdata_reg      <= 32'h0000_0000;
      resp_valid_reg <= 1'b0;
      adel_reg       <= 1'b0;
      ades_reg       <= 1'b0;
      buserr_reg     <= 1'b0;
      rdata_reg      <= 32'h0000_0000;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ex_ready_reg   <= (state_next == IDLE);
      busy_reg       <= (state_next == ADDR) || (state_next == DATA) || (state_next == DRAIN);
      bus_req_reg    <= (state_next == ADDR);
      resp_valid_reg <= (state_next == RESP);
      adel_reg       <= adel_next;
      ades_reg       <= ades_next;
      buserr_reg     <= buserr_next;
      rdata_reg      <= rdata_next;
      if (accept) begin
        op_reg     <= ex_memop;
        addr_reg   <= ex_addr;
        bus_wr_reg <= ~in_load;
        wstrb_reg  <= strb_in;
        wdata_reg  <= wdata_in;
      end
    end
  end

  assign ex_ready    = ex_ready_reg;
  // The idle term must react to ex_valid in the same cycle to hold upstream
  assign mem_stall   = busy_reg | (ex_ready_reg & ex_valid);
  assign bus_req     = bus_req_reg;
  assign bus_wr      = bus_wr_reg;
  assign bus_wstrb   = wstrb_reg;
  assign bus_addr    = addr_reg;
  assign bus_wdata   = wdata_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_rdata  = rdata_reg;
  assign resp_adel   = adel_reg;
  assign resp_ades   = ades_reg;
  assign resp_buserr = buserr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against an arithmetic
// reference model of alignment, strobes, lane replication and load extension.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, flush;
  logic [2:0]  ex_memop;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_ready, mem_stall;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        resp_valid, resp_adel, resp_ades, resp_buserr;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_ready(ex_ready), .flush(flush), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_adel(resp_adel), .resp_ades(resp_ades), .resp_buserr(resp_buserr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] a);
    int size;
    size = (op == 3'd0 || op == 3'd7) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_strb(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd5:    return 32'd1 << (a % 4);
      3'd6:    return 32'd3 << (a % 4);
      3'd7:    return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
    case (op)
      3'd5:    return (w & 32'hFF) * 32'h0101_0101;
      3'd6:    return (w & 32'hFFFF) * 32'h0001_0001;
      3'd7:    return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd0:    return rd;
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic present(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ex_valid = 1'b1; ex_memop = op; ex_addr = addr; ex_wdata = wd;
    #1;
    check_val("stall_on_valid", mem_stall, 1);
    tick;
    ex_valid = 1'b0; ex_memop = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
  endtask

  task automatic do_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int adly, input int ddly, input bit same);
    bit ld, mis;
    ld  = (op <= 3'd4);
    mis = model_misaligned(op, addr);
    present(op, addr, wd);
    if (mis) begin
      check_val("mis_resp_valid", resp_valid, 1);
      check_val("mis_adel", resp_adel, ld);
      check_val("mis_ades", resp_ades, !ld);
      check_val("mis_no_req", bus_req, 0);
      check_val("mis_rdata", resp_rdata, 0);
      tick;
      check_val("mis_ready_after", ex_ready, 1);
    end else begin
      check_val("req", bus_req, 1);
      check_val("wr", bus_wr, !ld);
      check_val("wstrb", bus_wstrb, model_strb(op, addr));
      check_val("wdata", bus_wdata, model_wdata(op, wd));
      check_val("addr", bus_addr, addr);
      for (int i = 0; i < adly; i++) begin
        bus_data_ok = 1'($urandom_range(0, 1));
        bus_rdata   = $urandom;
        tick;
        check_val("req_hold", bus_req, 1);
        check_val("stall_addr", mem_stall, 1);
      end
      bus_addr_ok = 1'b1;
      bus_data_ok = same;
      bus_rdata   = same ? rd : $urandom;
      tick;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (!same) begin
        check_val("req_drop_data", bus_req, 0);
        for (int i = 0; i < ddly; i++) begin
          bus_rdata = $urandom;
          tick;
          check_val("resp_wait", resp_valid, 0);
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        tick;
        bus_data_ok = 1'b0;
      end
      check_val("resp_valid", resp_valid, 1);
      check_val("resp_rdata", resp_rdata, ld ? model_load(op, addr, rd) : 32'd0);
      check_val("resp_flags", {resp_adel, resp_ades, resp_buserr}, 0);
      check_val("ready_in_resp", ex_ready, 0);
      tick;
      check_val("resp_one_cycle", resp_valid, 0);
      check_val("ready_after", ex_ready, 1);
    end
    $display("txn op=%0d addr=%h wdata=%h rdata=%h resp=%h mis=%0d", op, addr, wd, rd,
             ld ? model_load(op, addr, rd) : 32'd0, mis);
  endtask

  initial begin
    int cnt;
    logic [2:0]  op;
    logic [31:0] a;
    resetn = 1'b0; ex_valid = 1'b0; flush = 1'b0; ex_memop = 3'd0;
    ex_addr = 32'd0; ex_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    tick; tick;
    check_val("rst_ready", ex_ready, 1);
    check_val("rst_req", bus_req, 0);
    check_val("rst_resp", resp_valid, 0);
    check_val("rst_stall", mem_stall, 0);
    check_val("rst_wstrb", bus_wstrb, 0);
    resetn = 1'b1;
    tick;

    do_access(3'd3, 32'h1003, 32'd0, 32'h8011_2233, 0, 0, 0);
    do_access(3'd4, 32'h1003, 32'd0, 32'h8011_2233, 0, 0, 0);
    do_access(3'd6, 32'h1002, 32'h0000_ABCD, 32'd0, 0, 0, 0);
    do_access(3'd0, 32'h1002, 32'd0, 32'd0, 0, 0, 0);
    do_access(3'd7, 32'h1001, 32'h1234_5678, 32'd0, 0, 0, 0);
    do_access(3'd1, 32'h2006, 32'd0, 32'h9abc_1234, 1, 2, 1);

    // Flush while idle: nothing accepted
    ex_valid = 1'b1; flush = 1'b1; ex_memop = 3'd0; ex_addr = 32'h40;
    tick;
    ex_valid = 1'b0; flush = 1'b0;
    check_val("idle_flush_ready", ex_ready, 1);
    check_val("idle_flush_req", bus_req, 0);
    $display("txn idle flush");

    // Address-phase timeout
    present(3'd0, 32'h3000, 32'd0);
    cnt = 0;
    for (int i = 0; i < 200 && !resp_valid; i++) begin
      if (bus_req) cnt++;
      tick;
    end
    check_val("to_resp", resp_valid, 1);
    check_val("to_req_cycles", cnt, 64);
    check_val("to_buserr", resp_buserr, 1);
    check_val("to_req_low", bus_req, 0);
    check_val("to_rdata", resp_rdata, 0);
    tick;
    check_val("to_idle", ex_ready, 1);
    $display("txn timeout req_cycles=%0d", cnt);

    // Flush before addr_ok
    present(3'd7, 32'h3004, 32'h55AA_55AA);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check_val("fa_ready", ex_ready, 1);
    check_val("fa_req", bus_req, 0);
    check_val("fa_resp", resp_valid, 0);
    $display("txn flush in ADDR");

    // Flush during data phase drains
    present(3'd0, 32'h3008, 32'd0);
    bus_addr_ok = 1'b1;
    tick;
    bus_addr_ok = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("drain_stall", mem_stall, 1);
      check_val("drain_resp", resp_valid, 0);
      tick;
    end
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick;
    bus_data_ok = 1'b0;
    check_val("drain_ready", ex_ready, 1);
    check_val("drain_no_resp", resp_valid, 0);
    $display("txn flush in DATA");

    // Reset during data phase
    present(3'd0, 32'h300C, 32'd0);
    bus_addr_ok = 1'b1;
    tick;
    bus_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    check_val("arst_req", bus_req, 0);
    check_val("arst_ready", ex_ready, 1);
    check_val("arst_stall", mem_stall, 0);
    tick;
    resetn = 1'b1;
    tick;
    $display("txn reset in DATA");
    do_access(3'd0, 32'h3010, 32'd0, 32'hCAFE_F00D, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ((op == 3'd0 || op == 3'd7) ? 32'hFFFF_FFFC : 32'hFFFF_FFFE);
      do_access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
